uart_tx: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 19 +
 rtl/uart_tx_bit_timer.sv | 28 ++
 rtl/uart_tx.sv | 139 +++++++++++++
 tb/tb_uart_tx.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter.
// Holds the FSM encoding, the parity selectors and the idle line level.
package uart_tx_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    localparam logic PAR_EVEN      = 1'b0;
    localparam logic PAR_ODD       = 1'b1;
    localparam logic TX_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer for the UART transmitter.
// Produces a pulse on the last cycle of each Prescale_eff-cycle bit slot.
module uart_tx_bit_timer #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      load,
    input  logic [PRESCALE_WIDTH-1:0] Prescale_eff,
    output logic                      bit_done
);

    logic [PRESCALE_WIDTH-1:0] cnt;

    assign bit_done = (cnt == (Prescale_eff - PRESCALE_WIDTH'(1)));

    // Restarting on load aligns the first slot with the accept edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt <= '0;
        end else if (load || bit_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESCALE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit.
// TX_OUT and busy are registered; configuration is captured when a byte is accepted.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_t                 state, state_next;
    logic [DATA_WIDTH-1:0]     data_reg;
    logic                      par_en_reg;
    logic                      par_typ_reg;
    logic [PRESCALE_WIDTH-1:0] prescale_reg;
    logic [PRESCALE_WIDTH-1:0] prescale_eff_in;
    logic [IDX_W-1:0]          bit_idx, bit_idx_next, idx_inc;
    logic                      tx_next, busy_next;
    logic                      accept;
    logic                      bit_done;
    logic                      parity_bit;

    assign prescale_eff_in = (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
    assign parity_bit      = (par_typ_reg == PAR_ODD) ? ~(^data_reg) : (^data_reg);
    assign idx_inc         = bit_idx + IDX_W'(1);

    uart_tx_bit_timer #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_bit_timer (
        .CLK         (CLK),
        .RST         (RST),
        .load        (accept),
        .Prescale_eff(prescale_reg),
        .bit_done    (bit_done)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            TX_OUT  <= TX_IDLE_LEVEL;
            busy    <= 1'b0;
            bit_idx <= '0;
        end else begin
            state   <= state_next;
            TX_OUT  <= tx_next;
            busy    <= busy_next;
            bit_idx <= bit_idx_next;
        end
    end

    // Shadow copies keep the in-flight frame immune to input changes.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            data_reg     <= '0;
            par_en_reg   <= 1'b0;
            par_typ_reg  <= PAR_EVEN;
            prescale_reg <= '0;
        end else if (accept) begin
            data_reg     <= P_DATA;
            par_en_reg   <= PAR_EN;
            par_typ_reg  <= PAR_TYP;
            prescale_reg <= prescale_eff_in;
        end
    end

    always_comb begin
        state_next   = state;
        tx_next      = TX_OUT;
        busy_next    = busy;
        bit_idx_next = bit_idx;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                tx_next   = TX_IDLE_LEVEL;
                busy_next = 1'b0;
                if (Data_Valid) begin
                    accept     = 1'b1;
                    state_next = START;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    tx_next      = data_reg[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == LAST_IDX) begin
                        if (par_en_reg) begin
                            state_next = PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next = STOP;
                            tx_next    = TX_IDLE_LEVEL;
                        end
                    end else begin
                        bit_idx_next = idx_inc;
                        tx_next      = data_reg[idx_inc];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                    tx_next    = TX_IDLE_LEVEL;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_next = IDLE;
                    tx_next    = TX_IDLE_LEVEL;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = TX_IDLE_LEVEL;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx.
// Each frame is compared cycle by cycle against hand-derived line levels.
module tb_uart_tx;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [PW-1:0] Prescale;
    logic          TX_OUT;
    logic          busy;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    uart_tx #(
        .DATA_WIDTH    (DW),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .Prescale  (Prescale),
        .TX_OUT    (TX_OUT),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            checkOutput($sformatf("%s idle%0d tx", tag, i), TX_OUT, 1'b1);
            checkOutput($sformatf("%s idle%0d busy", tag, i), busy, 1'b0);
            tick();
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] data, input logic pen, input logic ptyp,
                                 input logic [PW-1:0] ps, input logic hold);
        P_DATA     = data;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        Prescale   = ps;
        Data_Valid = 1'b1;
        tick();
        if (!hold) Data_Valid = 1'b0;
    endtask

    // Called just after the accept edge; optionally fires a stray request mid-frame.
    task automatic checkFrame(input string tag, input logic [DW-1:0] data, input logic pen,
                              input logic par_val, input int pe, input int inject_cycle);
        logic [10:0] exp_bits;
        int nbits;
        int k;
        nbits = pen ? 11 : 10;
        k = 0;
        exp_bits = '1;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) exp_bits[1+i] = data[i];
        if (pen) exp_bits[9] = par_val;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < pe; c++) begin
                if (inject_cycle >= 0 && k == inject_cycle) begin
                    P_DATA     = 8'h3C;
                    Prescale   = 6'd32;
                    Data_Valid = 1'b1;
                end else if (inject_cycle >= 0 && k == inject_cycle + 1) begin
                    Data_Valid = 1'b0;
                end
                checkOutput($sformatf("%s bit%0d cyc%0d tx", tag, b, c), TX_OUT, exp_bits[b]);
                checkOutput($sformatf("%s bit%0d cyc%0d busy", tag, b, c), busy, 1'b1);
                tick();
                k++;
            end
        end
        checkOutput($sformatf("%s end busy", tag), busy, 1'b0);
        checkOutput($sformatf("%s end tx", tag), TX_OUT, 1'b1);
    endtask

    initial begin
        RST        = 1'b0;
        Data_Valid = 1'b1;
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd1;
        tick();
        checkOutput("reset0 tx", TX_OUT, 1'b1);
        checkOutput("reset0 busy", busy, 1'b0);
        tick();
        checkOutput("reset1 tx", TX_OUT, 1'b1);
        checkOutput("reset1 busy", busy, 1'b0);
        RST        = 1'b1;
        Data_Valid = 1'b0;
        checkIdle("post_reset", 3);

        applyStimulus(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
        checkFrame("basic_a5", 8'hA5, 1'b0, 1'b0, 8, -1);
        checkIdle("gap1", 2);

        applyStimulus(8'h07, 1'b1, 1'b0, 6'd16, 1'b0);
        checkFrame("par_even", 8'h07, 1'b1, 1'b1, 16, -1);
        checkIdle("gap2", 2);

        applyStimulus(8'h07, 1'b1, 1'b1, 6'd16, 1'b0);
        checkFrame("par_odd", 8'h07, 1'b1, 1'b0, 16, -1);
        checkIdle("gap3", 2);

        applyStimulus(8'h00, 1'b0, 1'b0, 6'd8, 1'b1);
        P_DATA = 8'hFF;
        checkFrame("b2b_first", 8'h00, 1'b0, 1'b0, 8, -1);
        tick();
        Data_Valid = 1'b0;
        checkFrame("b2b_second", 8'hFF, 1'b0, 1'b0, 8, -1);
        checkIdle("gap4", 2);

        applyStimulus(8'h96, 1'b0, 1'b0, 6'd8, 1'b0);
        checkFrame("masking", 8'h96, 1'b0, 1'b0, 8, 30);
        checkIdle("no_second", 40);

        applyStimulus(8'h5A, 1'b0, 1'b0, 6'd0, 1'b0);
        checkFrame("prescale0", 8'h5A, 1'b0, 1'b0, 1, -1);
        checkIdle("gap5", 2);

        applyStimulus(8'h0F, 1'b0, 1'b0, 6'd4, 1'b0);
        repeat (21) tick();
        checkOutput("abort pre tx", TX_OUT, 1'b0);
        checkOutput("abort pre busy", busy, 1'b1);
        RST = 1'b0;
        tick();
        checkOutput("abort tx", TX_OUT, 1'b1);
        checkOutput("abort busy", busy, 1'b0);
        RST = 1'b1;
        checkIdle("after_abort", 60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
